// File: rtl/median_pkg.sv
// Shared types for the median filter front end: default sizes,
// the pixel type and the window feeder FSM state encoding.
package median_pkg;

    localparam int DEF_PIX_W   = 8;
    localparam int DEF_LINE_W  = 64;
    localparam int DEF_FRAME_H = 64;

    // Bit 0 is the MSB, matching the pixel bus ordering.
    typedef logic [0:DEF_PIX_W-1] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL0,
        FILL1,
        STREAM
    } state_t;

endpackage

// File: rtl/median_line_buf.sv
// One line of pixel storage indexed by column.
// Ports: clk, we, addr, wdata in; rdata out.
// The read is combinational and the write lands on the clock edge,
// so a same-address read in the write cycle returns the old pixel.
module median_line_buf #(
    parameter int PIX_W  = 8,
    parameter int LINE_W = 64,
    parameter int AW     = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [0:PIX_W-1] wdata,
    output logic [0:PIX_W-1] rdata
);

    // Contents are deliberately left unreset.
    logic [0:PIX_W-1] r_mem [LINE_W];

    assign rdata = r_mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/median_window_feeder.sv
// Raster-to-column front end: emits (r-2, r-1, r) column triples.
// In: clk1, rst_n, pix_in, pix_valid, sof, hold.
// Out: pix_ready, A, B, C, win_valid, win_col, win_row, frame_done.
// Build option: BORDER_REPLICATE_EN also emits windows on rows 0 and 1.
module median_window_feeder
    import median_pkg::*;
#(
    parameter int PIX_W   = DEF_PIX_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int FRAME_H = DEF_FRAME_H,
    parameter int COL_W   = 6,
    parameter int ROW_W   = 6
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic [0:PIX_W-1] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic             pix_ready,
    input  logic             hold,
    output logic [0:PIX_W-1] A,
    output logic [0:PIX_W-1] B,
    output logic [0:PIX_W-1] C,
    output logic             win_valid,
    output logic [COL_W-1:0] win_col,
    output logic [ROW_W-1:0] win_row,
    output logic             frame_done
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_H - 1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    logic [0:PIX_W-1] r_a;
    logic [0:PIX_W-1] r_b;
    logic [0:PIX_W-1] r_c;
    logic [COL_W-1:0] r_wcol;
    logic [ROW_W-1:0] r_wrow;
    logic             r_wvalid;
    logic             r_fdone;

    logic             w_acc;
    logic             w_write;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_emit;
    logic [0:PIX_W-1] w_a;
    logic [0:PIX_W-1] w_b;
    logic [0:PIX_W-1] w_l0_rd;
    logic [0:PIX_W-1] w_l1_rd;

    assign pix_ready = rst_n & ~hold;
    assign w_acc     = pix_valid & pix_ready;

    // An accepted sof pixel is always (0,0), whatever the counters say.
    assign w_col = sof ? '0 : r_col;
    assign w_row = sof ? '0 : r_row;

    // IDLE drops every pixel except a frame start.
    assign w_write    = w_acc & (sof | (r_state != IDLE));
    assign w_last_col = (w_col == LAST_COL);
    assign w_last_row = (w_row == LAST_ROW);

    // L1 holds row r-1; L0 takes over L1's old pixel as row r-2.
    median_line_buf #(
        .PIX_W  (PIX_W),
        .LINE_W (LINE_W),
        .AW     (COL_W)
    ) u_l0 (
        .clk   (clk1),
        .we    (w_write),
        .addr  (w_col),
        .wdata (w_l1_rd),
        .rdata (w_l0_rd)
    );

    median_line_buf #(
        .PIX_W  (PIX_W),
        .LINE_W (LINE_W),
        .AW     (COL_W)
    ) u_l1 (
        .clk   (clk1),
        .we    (w_write),
        .addr  (w_col),
        .wdata (pix_in),
        .rdata (w_l1_rd)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_acc) begin
            unique case (r_state)
                IDLE: begin
                    if (sof) begin
                        w_state_nx = FILL0;
                    end
                end
                FILL0: begin
                    if (sof) begin
                        w_state_nx = FILL0;
                    end else if (w_last_col) begin
                        w_state_nx = FILL1;
                    end
                end
                FILL1: begin
                    if (sof) begin
                        w_state_nx = FILL0;
                    end else if (w_last_col) begin
                        w_state_nx = STREAM;
                    end
                end
                STREAM: begin
                    if (sof) begin
                        w_state_nx = FILL0;
                    end else if (w_last_col && w_last_row) begin
                        w_state_nx = IDLE;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // Window select. A restart pixel outside IDLE never emits.
    always_comb begin
        w_emit = 1'b0;
        w_a    = w_l0_rd;
        w_b    = w_l1_rd;
        if (w_acc) begin
            unique case (r_state)
                IDLE: begin
`ifdef BORDER_REPLICATE_EN
                    if (sof) begin
                        w_emit = 1'b1;
                        w_a    = pix_in;
                        w_b    = pix_in;
                    end
`endif
                end
                FILL0: begin
`ifdef BORDER_REPLICATE_EN
                    if (!sof) begin
                        w_emit = 1'b1;
                        w_a    = pix_in;
                        w_b    = pix_in;
                    end
`endif
                end
                FILL1: begin
`ifdef BORDER_REPLICATE_EN
                    if (!sof) begin
                        w_emit = 1'b1;
                        w_a    = w_l1_rd;
                        w_b    = w_l1_rd;
                    end
`endif
                end
                STREAM: begin
                    w_emit = ~sof;
                end
                default: w_emit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_write) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row + ROW_W'(1);
            end else begin
                r_col <= w_col + COL_W'(1);
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_wcol   <= '0;
            r_wrow   <= '0;
            r_wvalid <= 1'b0;
            r_fdone  <= 1'b0;
        end else begin
            r_wvalid <= w_emit;
            r_fdone  <= w_emit & w_last_col & w_last_row;
            if (w_emit) begin
                r_a    <= w_a;
                r_b    <= w_b;
                r_c    <= pix_in;
                r_wcol <= w_col;
                r_wrow <= w_row;
            end
        end
    end

    assign A          = r_a;
    assign B          = r_b;
    assign C          = r_c;
    assign win_col    = r_wcol;
    assign win_row    = r_wrow;
    assign win_valid  = r_wvalid;
    assign frame_done = r_fdone;

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder on a 4x4 frame: vector table,
// directed corner sequences and random traffic against a frame model.
module tb_median_window_feeder;

    localparam int LW = 4;
    localparam int FH = 4;
`ifdef BORDER_REPLICATE_EN
    localparam bit BRD = 1'b1;
`else
    localparam bit BRD = 1'b0;
`endif

    logic       clk1 = 1'b0;
    logic       rst_n;
    logic [0:7] pix_in;
    logic       pix_valid;
    logic       sof;
    logic       pix_ready;
    logic       hold;
    logic [0:7] A;
    logic [0:7] B;
    logic [0:7] C;
    logic       win_valid;
    logic [1:0] win_col;
    logic [1:0] win_row;
    logic       frame_done;

    median_window_feeder #(
        .PIX_W   (8),
        .LINE_W  (LW),
        .FRAME_H (FH),
        .COL_W   (2),
        .ROW_W   (2)
    ) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .pix_ready  (pix_ready),
        .hold       (hold),
        .A          (A),
        .B          (B),
        .C          (C),
        .win_valid  (win_valid),
        .win_col    (win_col),
        .win_row    (win_row),
        .frame_done (frame_done)
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;

    // Reference model: the frame as a picture plus a raster position.
    logic [7:0] img [FH][LW];
    bit         m_act;
    int         m_r;
    int         m_c;
    logic [7:0] e_a, e_b, e_c;
    int         e_row, e_col;
    bit         e_v, e_fd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_r = 0; m_c = 0;
        e_a = 0; e_b = 0; e_c = 0;
        e_row = 0; e_col = 0; e_v = 0; e_fd = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input bit h,
                              input logic [7:0] p);
        bit restart;
        bit emit;
        e_v = 0;
        e_fd = 0;
        if (v && !h && (s || m_act)) begin
            restart = s && m_act;
            if (s) begin
                m_act = 1; m_r = 0; m_c = 0;
            end
            emit = !restart && (m_r >= 2 || BRD);
            if (emit) begin
                e_a = (m_r >= 2) ? img[m_r-2][m_c] :
                      (m_r == 1) ? img[0][m_c] : p;
                e_b = (m_r >= 1) ? img[m_r-1][m_c] : p;
                e_c = p;
                e_row = m_r;
                e_col = m_c;
                e_v = 1;
                e_fd = (m_r == FH - 1) && (m_c == LW - 1);
            end
            img[m_r][m_c] = p;
            if (m_c == LW - 1) begin
                m_c = 0;
                if (m_r == FH - 1) begin
                    m_r = 0;
                    m_act = 0;
                end else begin
                    m_r++;
                end
            end else begin
                m_c++;
            end
        end
    endtask

    task automatic check_model();
        chk("win_valid", win_valid, e_v);
        chk("frame_done", frame_done, e_fd);
        chk("A", A, e_a);
        chk("B", B, e_b);
        chk("C", C, e_c);
        chk("win_row", win_row, e_row);
        chk("win_col", win_col, e_col);
    endtask

    // Called one time unit after an active edge.
    task automatic cyc(input bit v, input bit s, input bit h,
                       input logic [7:0] p);
        pix_valid = v;
        sof = s;
        hold = h;
        pix_in = p;
        #1;
        chk("pix_ready", pix_ready, !h);
        @(posedge clk1);
        model_step(v, s, h, p);
        #1;
        check_model();
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_win_valid", win_valid, 0);
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_C", C, 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pix_ready", pix_ready, 0);
        model_reset();
        @(posedge clk1);
        #2;
        rst_n = 1'b1;
        @(posedge clk1);
        #1;
    endtask

    function automatic logic [7:0] px(input int k);
        return 8'((k / LW) * 16 + (k % LW));
    endfunction

    task automatic send(input int from, input int upto, input bit s0);
        for (int k = from; k < upto; k++) begin
            cyc(1, s0 && (k == from), 0, px(k));
        end
    endtask

    typedef struct {
        bit         v;
        bit         s;
        logic [7:0] pix;
        bit         ev;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] ec;
        bit         fd;
    } vec_t;

    vec_t tv [LW*FH+1];

    task automatic run_table();
        for (int i = 0; i < LW * FH + 1; i++) begin
            cyc(tv[i].v, tv[i].s, 0, tv[i].pix);
            chk("tbl_valid", win_valid, tv[i].ev);
            chk("tbl_fdone", frame_done, tv[i].fd);
            if (tv[i].ev) begin
                chk("tbl_A", A, tv[i].ea);
                chk("tbl_B", B, tv[i].eb);
                chk("tbl_C", C, tv[i].ec);
            end
            if (tv[i].v && tv[i].pix == 8'h20) begin
                chk("p20_A", A, 8'h00);
                chk("p20_B", B, 8'h10);
                chk("p20_C", C, 8'h20);
                chk("p20_row", win_row, 2);
                chk("p20_col", win_col, 0);
            end
            if (tv[i].v && tv[i].pix == 8'h33) begin
                chk("p33_A", A, 8'h13);
                chk("p33_B", B, 8'h23);
                chk("p33_C", C, 8'h33);
                chk("p33_fdone", frame_done, 1);
            end
`ifdef BORDER_REPLICATE_EN
            if (tv[i].v && tv[i].pix == 8'h00) begin
                chk("brd00_A", A, 8'h00);
                chk("brd00_B", B, 8'h00);
                chk("brd00_C", C, 8'h00);
            end
            if (tv[i].v && tv[i].pix == 8'h12) begin
                chk("brd12_A", A, 8'h02);
                chk("brd12_B", B, 8'h02);
                chk("brd12_C", C, 8'h12);
            end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < LW * FH; i++) begin
            int r;
            int c;
            r = i / LW;
            c = i % LW;
            tv[i].v   = 1;
            tv[i].s   = (i == 0);
            tv[i].pix = px(i);
            tv[i].ev  = (r >= 2) || BRD;
            tv[i].ea  = (r >= 2) ? 8'((r - 2) * 16 + c) :
                        (r == 1) ? 8'(c) : px(i);
            tv[i].eb  = (r >= 1) ? 8'((r - 1) * 16 + c) : px(i);
            tv[i].ec  = px(i);
            tv[i].fd  = (i == LW * FH - 1);
        end
        tv[LW*FH] = '{v: 0, s: 0, pix: 8'h00, ev: 0,
                      ea: 8'h0, eb: 8'h0, ec: 8'h0, fd: 0};

        rst_n = 1'b0;
        pix_valid = 0;
        sof = 0;
        hold = 0;
        pix_in = 0;
        model_reset();
        #1;
        chk("init_pix_ready", pix_ready, 0);
        chk("init_win_valid", win_valid, 0);
        chk("init_frame_done", frame_done, 0);
        @(posedge clk1);
        #2;
        rst_n = 1'b1;
        @(posedge clk1);
        #1;

        // Pixels before any sof are dropped.
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 8'(8'h40 + k));
            chk("nosof_valid", win_valid, 0);
        end

        // Full frame from IDLE, then trailing idle cycle.
        run_table();

        // Hold on pixel 0x21.
        send(0, 9, 1);
        cyc(1, 0, 1, 8'h21);
        chk("hold_valid", win_valid, 0);
        chk("hold_A", A, 8'h00);
        chk("hold_B", B, 8'h10);
        chk("hold_C", C, 8'h20);
        cyc(1, 1, 1, 8'h99);
        chk("hold_sof_valid", win_valid, 0);
        cyc(1, 0, 0, 8'h21);
        chk("rel_A", A, 8'h01);
        chk("rel_B", B, 8'h11);
        chk("rel_C", C, 8'h21);
        send(10, LW * FH, 0);

        // Restart on pixel 0x22.
        send(0, 10, 1);
        cyc(1, 1, 0, 8'h22);
        chk("restart_valid", win_valid, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 0, 0, px(k));
`ifndef BORDER_REPLICATE_EN
            chk("post_restart_valid", win_valid, k == 8);
`endif
        end
        send(9, LW * FH, 0);

        // Asynchronous reset mid-frame, at row 2 column 1.
        send(0, 9, 1);
        pulse_reset();
        run_table();

        // Random traffic, occasional sof and reset.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                cyc($urandom_range(0, 3) != 0,
                    $urandom_range(0, 40) == 0,
                    $urandom_range(0, 4) == 0,
                    8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
